// File: rtl/montador_face_cubo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : montador_face_cubo_pkg
// Brief    : Shared definitions for the camera blocks: colour codes, face
//            assembler FSM state encodings and default colour thresholds.
// Revision : 1.0 - initial release
// ============================================================================
package montador_face_cubo_pkg;

   // Rubik's-cube sticker colour codes (code 6 is never produced)
   localparam logic [2:0] COR_BRANCO       = 3'd0;
   localparam logic [2:0] COR_AMARELO      = 3'd1;
   localparam logic [2:0] COR_VERMELHO     = 3'd2;
   localparam logic [2:0] COR_LARANJA      = 3'd3;
   localparam logic [2:0] COR_VERDE        = 3'd4;
   localparam logic [2:0] COR_AZUL         = 3'd5;
   localparam logic [2:0] COR_DESCONHECIDA = 3'd7;

   // Default 5-bit channel thresholds
   localparam int T_HI_PADRAO = 20;
   localparam int T_LO_PADRAO = 10;

   // Number of stickers on one face (3x3, row-major)
   localparam int NUM_CELULAS = 9;

   // Face assembler FSM; the encoding is exported on db_estado
   typedef enum logic [2:0] {
      ESPERA_MSB = 3'd0,
      ESPERA_LSB = 3'd1,
      CLASSIFICA = 3'd2,
      ESCREVE    = 3'd3,
      COMPLETA   = 3'd4
   } estado_t;

endpackage : montador_face_cubo_pkg
`default_nettype wire

// File: rtl/montador_face_cubo_classificador.sv
`default_nettype none
// ============================================================================
// Module   : classificador_cor
// Brief    : Combinational RGB565 -> cube colour classifier. Channels are
//            compared as unsigned 5-bit levels against T_HI / T_LO; the
//            first matching rule wins.
// Revision : 1.0 - initial release
// ============================================================================
module classificador_cor
   import montador_face_cubo_pkg::*;
#(
   parameter int T_HI = T_HI_PADRAO,
   parameter int T_LO = T_LO_PADRAO
) (
   input  logic [15:0] pixel,
   output logic [2:0]  cor
);

   localparam logic [4:0] c_hi = 5'(T_HI);
   localparam logic [4:0] c_lo = 5'(T_LO);

   logic [4:0] w_r;
   logic [4:0] w_g;
   logic [4:0] w_b;

   // G keeps only its top 5 bits so all channels share one scale
   assign w_r = pixel[15:11];
   assign w_g = pixel[10:6];
   assign w_b = pixel[4:0];

   // Priority rule chain; order matters (white before yellow, etc.)
   always_comb begin
      cor = COR_DESCONHECIDA;
      if (w_r >= c_hi && w_g >= c_hi && w_b >= c_hi)
         cor = COR_BRANCO;
      else if (w_r >= c_hi && w_g >= c_hi && w_b < c_lo)
         cor = COR_AMARELO;
      else if (w_r >= c_hi && w_g >= c_lo && w_g < c_hi && w_b < c_lo)
         cor = COR_LARANJA;
      else if (w_r >= c_hi && w_g < c_lo && w_b < c_lo)
         cor = COR_VERMELHO;
      else if (w_g >= c_hi && w_r < c_lo && w_b < c_hi)
         cor = COR_VERDE;
      else if (w_b >= c_hi && w_r < c_lo)
         cor = COR_AZUL;
   end

endmodule : classificador_cor
`default_nettype wire

// File: rtl/montador_face_cubo.sv
`default_nettype none
// ============================================================================
// Module   : montador_face_cubo
// Brief    : Pairs camera bytes into RGB565 pixels (MSB first), classifies
//            each pixel into a cube colour and stores the 9 stickers of one
//            face in a row-major 3x3 buffer with combinational read-back.
//            Optional macro BYTE_TIMEOUT_EN adds an MSB->LSB timeout.
// Revision : 1.0 - initial release
// ============================================================================
module montador_face_cubo
   import montador_face_cubo_pkg::*;
#(
   parameter int T_HI           = T_HI_PADRAO,
   parameter int T_LO           = T_LO_PADRAO,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inicia,
   input  logic        byte_valido,
   input  logic [7:0]  byte_in,
   input  logic [3:0]  ler_addr,
   output logic [2:0]  cor_lida,
   output logic        face_pronta,
   output logic [3:0]  indice,
   output logic [15:0] pixel_rgb,
   output logic        erro,
   output logic [2:0]  db_estado
);

   estado_t     r_estado;
   estado_t     w_proximo;
   logic [7:0]  r_msb;
   logic [15:0] r_pixel;
   logic [2:0]  r_classe;
   logic [2:0]  w_classe;
   logic [3:0]  r_indice;
   logic        r_erro;
   logic [2:0]  r_buffer [NUM_CELULAS];
   logic        w_timeout;

   classificador_cor #(
      .T_HI (T_HI),
      .T_LO (T_LO)
   ) u_classificador (
      .pixel (r_pixel),
      .cor   (w_classe)
   );

`ifdef BYTE_TIMEOUT_EN
   localparam int c_largura_cont = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [c_largura_cont-1:0] r_cont;

   // Cycle counter: zero outside ESPERA_LSB, so it starts at 0 on entry
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_cont <= '0;
      else if (r_estado != ESPERA_LSB)
         r_cont <= '0;
      else
         r_cont <= r_cont + 1'b1;
   end

   // A byte arriving on the last allowed cycle still wins over the timeout
   assign w_timeout = (r_estado == ESPERA_LSB) && !byte_valido &&
                      (r_cont == c_largura_cont'(TIMEOUT_CYCLES - 1));
`else
   // No timeout in this build; constant 0 for any legal TIMEOUT_CYCLES
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_estado <= ESPERA_MSB;
      else
         r_estado <= w_proximo;
   end

   // Next-state logic; inicia overrides everything, including a same-cycle byte
   always_comb begin
      w_proximo = r_estado;
      if (inicia) begin
         w_proximo = ESPERA_MSB;
      end else begin
         case (r_estado)
            ESPERA_MSB: if (byte_valido) w_proximo = ESPERA_LSB;
            ESPERA_LSB: begin
               if (byte_valido)
                  w_proximo = CLASSIFICA;
               else if (w_timeout)
                  w_proximo = ESPERA_MSB;
            end
            CLASSIFICA: w_proximo = ESCREVE;
            ESCREVE:    w_proximo = (r_indice == 4'd8) ? COMPLETA : ESPERA_MSB;
            COMPLETA:   w_proximo = COMPLETA;
            default:    w_proximo = ESPERA_MSB;
         endcase
      end
   end

   // Assembled pixel; cleared by reset only, kept across inicia
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_pixel <= '0;
      else if (!inicia && r_estado == ESPERA_LSB && byte_valido)
         r_pixel <= {r_msb, byte_in};
   end

   // Face datapath: MSB latch, class register, buffer, write index, error flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_msb    <= '0;
         r_classe <= COR_DESCONHECIDA;
         r_indice <= '0;
         r_erro   <= 1'b0;
         for (int i = 0; i < NUM_CELULAS; i++)
            r_buffer[i] <= COR_DESCONHECIDA;
      end else if (inicia) begin
         r_classe <= COR_DESCONHECIDA;
         r_indice <= '0;
         r_erro   <= 1'b0;
         for (int i = 0; i < NUM_CELULAS; i++)
            r_buffer[i] <= COR_DESCONHECIDA;
      end else begin
         case (r_estado)
            ESPERA_MSB: begin
               if (byte_valido)
                  r_msb <= byte_in;
            end
            ESPERA_LSB: begin
               if (w_timeout)
                  r_erro <= 1'b1;
            end
            CLASSIFICA: begin
               r_classe <= w_classe;
               if (byte_valido)
                  r_erro <= 1'b1;
            end
            ESCREVE: begin
               r_buffer[r_indice] <= r_classe;
               r_indice           <= r_indice + 4'd1;
               if (byte_valido)
                  r_erro <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Combinational read-back; out-of-range addresses read as unknown
   always_comb begin
      cor_lida = COR_DESCONHECIDA;
      if (ler_addr < 4'(NUM_CELULAS))
         cor_lida = r_buffer[ler_addr];
   end

   assign face_pronta = (r_estado == COMPLETA);
   assign indice      = r_indice;
   assign pixel_rgb   = r_pixel;
   assign erro        = r_erro;
   assign db_estado   = r_estado;

endmodule : montador_face_cubo
`default_nettype wire

// File: doc/montador_face_cubo.md
Name: montador_face_cubo

Overview:
- Downstream stage of the OV7670 capture datapath.
- Consumes the byte stream produced by the camera serial receiver: an 8-bit byte plus its single-cycle "reception done" strobe.
- Pairs bytes into RGB565 pixels, MSB first, and classifies each pixel into a Rubik's-cube colour code.
- Stores the 9 sticker colours of one face in a 3x3 buffer, row-major. The buffer is read back by the solver/control logic.

Parameters:
- T_HI, default 20: 5-bit channel level at or above which a channel counts as "high".
- T_LO, default 10: 5-bit channel level below which a channel counts as "low".
- TIMEOUT_CYCLES, default 50000: maximum cycles between MSB and LSB. Used only with BYTE_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- inicia  in  1  synchronous pulse: start capture of a new face.
- byte_valido  in  1  single-cycle strobe: byte_in is valid.
- byte_in  in  8  received camera byte.
- ler_addr  in  4  read index 0..8, row-major (row*3+col).
- cor_lida  out  3  colour at ler_addr; combinational read.
- face_pronta  out  1  high while all 9 entries hold fresh data.
- indice  out  4  next write index, 0..9.
- pixel_rgb  out  16  last assembled pixel.
- erro  out  1  sticky error flag.
- db_estado  out  3  FSM state encoding.

Behaviour:
- Reset (async) and inicia (sync, any state) have the same effect:
  - state ESPERA_MSB
  - indice=0, face_pronta=0, erro=0
  - all 9 buffer entries = 7 (unknown)
  - pixel_rgb=0 (on reset only; inicia keeps it)
- cor_lida = buffer[ler_addr]. If ler_addr > 8, cor_lida = 7.
- FSM states:
  - ESPERA_MSB: on byte_valido, latch byte_in as MSB, go to ESPERA_LSB.
  - ESPERA_LSB: on byte_valido, pixel_rgb <= {MSB, byte_in}, go to CLASSIFICA.
  - CLASSIFICA: register the classifier output of pixel_rgb, go to ESCREVE.
  - ESCREVE: buffer[indice] <= class; indice++. If the old indice was 8, go to COMPLETA; otherwise go to ESPERA_MSB.
  - COMPLETA: face_pronta=1. byte_valido is ignored without error. Leave only on inicia or reset.
- Latency: LSB strobe in cycle t gives the write at the end of t+2. On the 9th pixel, face_pronta is high from t+3.
- A byte_valido during CLASSIFICA or ESCREVE is dropped and sets erro. The FSM path is unaffected.
- inicia and byte_valido in the same cycle: inicia wins and the byte is discarded.
- Classification:
  - Channel extraction: R=pixel[15:11]; G5=pixel[10:6] (top 5 of 6 G bits); B=pixel[4:0].
  - Comparisons are unsigned 5-bit. First match wins:
    1. white=0: R, G5, B all >= T_HI.
    2. yellow=1: R>=T_HI, G5>=T_HI, B<T_LO.
    3. orange=3: R>=T_HI, T_LO<=G5<T_HI, B<T_LO.
    4. red=2: R>=T_HI, G5<T_LO, B<T_LO.
    5. green=4: G5>=T_HI, R<T_LO, B<T_HI.
    6. blue=5: B>=T_HI, R<T_LO.
    7. otherwise unknown=7.
  - Code 6 is never produced.

Optional Feature:
- Macro: BYTE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ESPERA_LSB and counts while in that state.
  - On reaching TIMEOUT_CYCLES-1 with no byte_valido: discard the MSB, set erro, return to ESPERA_MSB. indice is unchanged.
  - byte_valido in that same cycle wins: the pixel is accepted.
- Not defined: ESPERA_LSB waits indefinitely; no counter is synthesised.

Decomposition:
- Shared package (with the other camera blocks) holds:
  - colour code constants: COR_BRANCO=0, COR_AMARELO=1, COR_VERMELHO=2, COR_LARANJA=3, COR_VERDE=4, COR_AZUL=5, COR_DESCONHECIDA=7
  - FSM state encodings
  - default thresholds
- One sub-module, classificador_cor:
  - purely combinational, 16-bit pixel in, 3-bit code out
  - parameterised by T_HI/T_LO
  - reused by any later colour-calibration block.

Test Plan:
1. Reset then idle: cor_lida=7 for ler_addr 0..15; face_pronta=0, indice=0, erro=0, db_estado=ESPERA_MSB.
2. Classification, one pixel each after inicia, checking cor_lida at addresses 0..6:
   - FFFF->0, FFE0->1, F800->2, FC00->3, 07E0->4, 001F->5, 0000->7.
3. Full face: 18 bytes encoding 9 pixels (colours 0,1,2,3,4,5,0,1,2):
   - face_pronta rises exactly 3 cycles after the 18th strobe; indice=9.
   - Extra bytes are then ignored; erro stays 0.
4. Overrun: byte_valido one cycle after an LSB strobe (in CLASSIFICA) -> erro=1; that pixel is still written; indice increments once.
5. inicia mid-face after 5 pixels -> indice=0, all entries 7, face_pronta=0. A following 0x001F pixel lands at entry 0 as 5.
6. With BYTE_TIMEOUT_EN and TIMEOUT_CYCLES=8:
   - MSB then no LSB -> erro=1 and return to ESPERA_MSB after 8 cycles.
   - The next two bytes F8,00 store red (2) at the unchanged indice.
